// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch, data and debug requesters onto one single-port memory.
// One transaction in flight; debug has priority, fetch/data round-robin.
module mem_port_arbiter #(
  parameter int AW     = 8,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_ack,
  input  logic          db_req,
  input  logic          db_we,
  input  logic [AW-1:0] db_addr,
  input  logic [DW-1:0] db_wdata,
  output logic          db_gnt,
  output logic          db_ack,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    OWN_IF,
    OWN_DM,
    OWN_DB
  } own_t;

  state_t        state;
  state_t        state_nx;
  own_t          owner;
  own_t          pick;
  logic          last_dm;
  logic [1:0]    cnt;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  logic          any_req;
  logic          c_if;
  logic          c_dm;
  logic          c_db;
  logic          pick_we;
  logic [AW-1:0] pick_addr;
  logic [DW-1:0] pick_wdata;

  assign any_req = if_req | dm_req | db_req;

  // last_dm set means data was served last, so fetch wins a tie
  always_comb begin
    c_db       = db_req;
    c_if       = !db_req && if_req && (!dm_req || last_dm);
    c_dm       = !db_req && dm_req && (!if_req || !last_dm);
    pick       = OWN_IF;
    pick_we    = 1'b0;
    pick_addr  = if_addr;
    pick_wdata = '0;
    unique case (1'b1)
      c_db: begin
        pick       = OWN_DB;
        pick_we    = db_we;
        pick_addr  = db_addr;
        pick_wdata = db_wdata;
      end
      c_dm: begin
        pick       = OWN_DM;
        pick_we    = dm_we;
        pick_addr  = dm_addr;
        pick_wdata = dm_wdata;
      end
      c_if: begin
        pick       = OWN_IF;
        pick_we    = 1'b0;
        pick_addr  = if_addr;
        pick_wdata = '0;
      end
      default: begin
        pick       = OWN_IF;
        pick_we    = 1'b0;
        pick_addr  = if_addr;
        pick_wdata = '0;
      end
    endcase
  end

  always_comb begin
    state_nx  = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    db_gnt    = 1'b0;
    if_ack    = 1'b0;
    dm_ack    = 1'b0;
    db_ack    = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (any_req) state_nx = ISSUE;
      end
      ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if_gnt    = (owner == OWN_IF);
        dm_gnt    = (owner == OWN_DM);
        db_gnt    = (owner == OWN_DB);
        state_nx  = we_q ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt == 2'd0) state_nx = RESP;
      end
      RESP: begin
        if_ack   = (owner == OWN_IF);
        dm_ack   = (owner == OWN_DM);
        db_ack   = (owner == OWN_DB);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      owner   <= OWN_IF;
      last_dm <= 1'b1;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_req) begin
        owner   <= pick;
        we_q    <= pick_we;
        addr_q  <= pick_addr;
        wdata_q <= pick_wdata;
      end
      if (state == ISSUE) begin
        cnt <= 2'(RD_LAT - 1);
        if (owner == OWN_IF) last_dm <= 1'b0;
        else if (owner == OWN_DM) last_dm <= 1'b1;
      end
      if (state == WAIT) begin
        if (cnt == 2'd0) rdata <= mem_rdata;
        else cnt <= cnt - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed steps plus random traffic against a
// transaction-level reference model; RD_LAT=1 and RD_LAT=3 instances.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_rst;
  logic        load;
  logic        sel;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        dm_req;
  logic        dm_we;
  logic [7:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic        db_req;
  logic        db_we;
  logic [7:0]  db_addr;
  logic [31:0] db_wdata;

  logic        if_gnt_a, if_ack_a, dm_gnt_a, dm_ack_a, db_gnt_a, db_ack_a;
  logic [31:0] rdata_a, mem_wdata_a, mem_rdata_a;
  logic        mem_en_a, mem_we_a, busy_a;
  logic [7:0]  mem_addr_a;
  logic        if_gnt_b, if_ack_b, dm_gnt_b, dm_ack_b, db_gnt_b, db_ack_b;
  logic [31:0] rdata_b, mem_wdata_b, mem_rdata_b;
  logic        mem_en_b, mem_we_b, busy_b;
  logic [7:0]  mem_addr_b;

  mem_port_arbiter #(.AW(8), .DW(32), .RD_LAT(1)) u_a (
    .clk(clk), .n_rst(n_rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_a), .if_ack(if_ack_a),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt_a), .dm_ack(dm_ack_a),
    .db_req(db_req), .db_we(db_we), .db_addr(db_addr), .db_wdata(db_wdata),
    .db_gnt(db_gnt_a), .db_ack(db_ack_a),
    .rdata(rdata_a), .mem_en(mem_en_a), .mem_we(mem_we_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a), .busy(busy_a)
  );

  mem_port_arbiter #(.AW(8), .DW(32), .RD_LAT(3)) u_b (
    .clk(clk), .n_rst(n_rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_b), .if_ack(if_ack_b),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt_b), .dm_ack(dm_ack_b),
    .db_req(db_req), .db_we(db_we), .db_addr(db_addr), .db_wdata(db_wdata),
    .db_gnt(db_gnt_b), .db_ack(db_ack_b),
    .rdata(rdata_b), .mem_en(mem_en_b), .mem_we(mem_we_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .busy(busy_b)
  );

  // memory devices: data valid exactly RD_LAT cycles after mem_en, junk otherwise
  logic [31:0] img    [256];
  logic [31:0] dmem_a [256];
  logic [31:0] dmem_b [256];
  logic [31:0] pd_a   [4];
  logic [31:0] pd_b   [4];

  always @(posedge clk) begin
    if (load) for (int i = 0; i < 256; i++) dmem_a[i] <= img[i];
    else if (mem_en_a && mem_we_a) dmem_a[mem_addr_a] <= mem_wdata_a;
    pd_a[0] <= (mem_en_a && !mem_we_a) ? dmem_a[mem_addr_a] : $urandom;
    for (int k = 1; k < 4; k++) pd_a[k] <= pd_a[k-1];
  end

  always @(posedge clk) begin
    if (load) for (int i = 0; i < 256; i++) dmem_b[i] <= img[i];
    else if (mem_en_b && mem_we_b) dmem_b[mem_addr_b] <= mem_wdata_b;
    pd_b[0] <= (mem_en_b && !mem_we_b) ? dmem_b[mem_addr_b] : $urandom;
    for (int k = 1; k < 4; k++) pd_b[k] <= pd_b[k-1];
  end

  assign mem_rdata_a = pd_a[0];
  assign mem_rdata_b = pd_b[2];

  logic [2:0]  o_gnt;
  logic [2:0]  o_ack;
  logic [41:0] o_mem;
  logic [31:0] o_rdata;
  logic        o_busy;

  assign o_gnt   = sel ? {db_gnt_b, dm_gnt_b, if_gnt_b}
                       : {db_gnt_a, dm_gnt_a, if_gnt_a};
  assign o_ack   = sel ? {db_ack_b, dm_ack_b, if_ack_b}
                       : {db_ack_a, dm_ack_a, if_ack_a};
  assign o_mem   = sel ? {mem_en_b, mem_we_b, mem_addr_b, mem_wdata_b}
                       : {mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a};
  assign o_rdata = sel ? rdata_b : rdata_a;
  assign o_busy  = sel ? busy_b : busy_a;

  // transaction-level reference model
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc;
  int          lat;
  int          gnt_cyc;
  int          ack_cyc;
  int          idle_from;
  int          m_own;
  logic        m_we;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rval;
  logic [31:0] exp_rdata;
  bit          last_dm;
  logic [31:0] ref_mem [256];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    gnt_cyc   = -1;
    ack_cyc   = -1;
    idle_from = 0;
    last_dm   = 1'b1;
    exp_rdata = '0;
    lat       = sel ? 3 : 1;
  endtask

  task automatic check_cycle();
    logic [2:0]  eg;
    logic [2:0]  ea;
    logic [41:0] em;
    eg = (cyc == gnt_cyc) ? 3'(3'b001 << m_own) : 3'b000;
    ea = (cyc == ack_cyc) ? 3'(3'b001 << m_own) : 3'b000;
    em = (cyc == gnt_cyc) ? {1'b1, m_we, m_addr, m_wdata} : '0;
    if (cyc == ack_cyc && !m_we) exp_rdata = m_rval;
    chk("gnt", 64'(o_gnt), 64'(eg));
    chk("ack", 64'(o_ack), 64'(ea));
    chk("mem", 64'(o_mem), 64'(em));
    chk("rdata", 64'(o_rdata), 64'(exp_rdata));
    chk("busy", 64'(o_busy), 64'(cyc >= gnt_cyc && cyc < idle_from));
  endtask

  task automatic arb();
    if (cyc >= idle_from && (if_req || dm_req || db_req)) begin
      if (db_req) m_own = 2;
      else if (if_req && dm_req) m_own = last_dm ? 0 : 1;
      else m_own = dm_req ? 1 : 0;
      unique case (m_own)
        0: begin m_we = 1'b0; m_addr = if_addr; m_wdata = '0; end
        1: begin m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata; end
        default: begin m_we = db_we; m_addr = db_addr; m_wdata = db_wdata; end
      endcase
      m_rval = ref_mem[m_addr];
      if (m_we) ref_mem[m_addr] = m_wdata;
      if (m_own != 2) last_dm = (m_own == 1);
      gnt_cyc   = cyc + 1;
      ack_cyc   = cyc + 2 + (m_we ? 0 : lat);
      idle_from = ack_cyc + 1;
    end
  endtask

  task automatic step();
    arb();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic clear_inputs();
    if_req = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    db_req = 0; db_we = 0; db_addr = '0; db_wdata = '0;
  endtask

  task automatic do_reset(input bit s);
    clear_inputs();
    n_rst = 1'b0;
    load  = 1'b1;
    sel   = s;
    @(posedge clk);
    @(posedge clk);
    #1;
    load  = 1'b0;
    n_rst = 1'b1;
    ref_mem = img;
    cyc = 0;
    model_reset();
    check_cycle();
  endtask

  task automatic rand_run(input int n);
    bit busy_r [3];
    bit cool   [3];
    for (int r = 0; r < 3; r++) busy_r[r] = 0;
    clear_inputs();
    for (int i = 0; i < n; i++) begin
      step();
      for (int r = 0; r < 3; r++) begin
        cool[r] = 0;
        if (o_gnt[r]) busy_r[r] = 1;
        if (o_ack[r]) begin busy_r[r] = 0; cool[r] = 1; end
      end
      if (o_gnt[0]) begin if_req = 0; if_addr = 8'($urandom); end
      if (o_gnt[1]) begin dm_req = 0; dm_addr = 8'($urandom); dm_wdata = $urandom; end
      if (o_gnt[2]) begin db_req = 0; db_addr = 8'($urandom); db_wdata = $urandom; end
      if (!if_req && !busy_r[0] && !cool[0] && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = 8'($urandom_range(0, 15));
      end else if (if_req && $urandom_range(0, 19) == 0) if_req = 0;
      if (!dm_req && !busy_r[1] && !cool[1] && $urandom_range(0, 2) == 0) begin
        dm_req = 1; dm_we = 1'($urandom); dm_addr = 8'($urandom_range(0, 15));
        dm_wdata = $urandom;
      end else if (dm_req && $urandom_range(0, 19) == 0) dm_req = 0;
      if (!db_req && !busy_r[2] && !cool[2] && $urandom_range(0, 7) == 0) begin
        db_req = 1; db_we = 1'($urandom); db_addr = 8'($urandom_range(0, 15));
        db_wdata = $urandom;
      end else if (db_req && $urandom_range(0, 19) == 0) db_req = 0;
    end
    clear_inputs();
    repeat (10) step();
  endtask

  logic [2:0]  pg;
  logic [31:0] r0;
  int          ng;

  initial begin
    for (int i = 0; i < 256; i++) img[i] = $urandom;
    img[8'h10] = 32'hDEADBEEF;
    img[8'h7F] = 32'hCAFEF00D;
    do_reset(1'b0);

    // single fetch, RD_LAT=1
    if_req = 1; if_addr = 8'h10;
    step();
    chk("t1_issue", 64'(o_mem), 64'({1'b1, 1'b0, 8'h10, 32'h0}));
    chk("t1_gnt", 64'(o_gnt), 64'(3'b001));
    if_req = 0;
    step();
    step();
    chk("t1_ack", 64'(o_ack), 64'(3'b001));
    chk("t1_rdata", 64'(o_rdata), 64'(32'hDEADBEEF));
    step();
    chk("t1_idle", 64'(o_busy), 64'(0));

    // fetch and data held together: grants alternate
    if_req = 1; if_addr = 8'h11;
    dm_req = 1; dm_we = 0; dm_addr = 8'h20;
    ng = 0; pg = '0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (o_gnt != 3'b000) begin
        if (ng > 0) chk("t2_alt", 64'(o_gnt),
                        64'((pg == 3'b001) ? 3'b010 : 3'b001));
        pg = o_gnt;
        ng++;
        if (ng >= 4 && o_gnt == 3'b010) begin
          if_req = 0; dm_req = 0;
          break;
        end
      end
    end
    chk("t2_grants", 64'(ng >= 4), 64'(1));
    repeat (6) step();

    // debug write beats waiting fetch and data
    db_req = 1; db_we = 1; db_addr = 8'h05; db_wdata = 32'h12345678;
    if_req = 1; if_addr = 8'h12; dm_req = 1; dm_we = 0; dm_addr = 8'h21;
    r0 = o_rdata;
    step();
    chk("t3_dbgnt", 64'(o_gnt), 64'(3'b100));
    chk("t3_mem", 64'(o_mem), 64'({1'b1, 1'b1, 8'h05, 32'h12345678}));
    db_req = 0;
    step();
    chk("t3_dback", 64'(o_ack), 64'(3'b100));
    chk("t3_rdata", 64'(o_rdata), 64'(r0));
    step();
    step();
    chk("t3_ifgnt", 64'(o_gnt), 64'(3'b001));
    if_req = 0; dm_req = 0;
    repeat (6) step();

    // debug arriving during a fetch wait is served next
    if_req = 1; if_addr = 8'h13;
    step();
    if_req = 0;
    step();
    db_req = 1; db_we = 0; db_addr = 8'h33;
    step();
    chk("t4_ifack", 64'(o_ack), 64'(3'b001));
    step();
    step();
    chk("t4_dbgnt", 64'(o_gnt), 64'(3'b100));
    db_req = 0;
    repeat (6) step();

    // reset during wait aborts the read silently
    dm_req = 1; dm_we = 0; dm_addr = 8'h44;
    step();
    dm_req = 0;
    step();
    n_rst = 1'b0;
    #2;
    chk("t5_gnt0", 64'(o_gnt), 64'(0));
    chk("t5_ack0", 64'(o_ack), 64'(0));
    chk("t5_mem0", 64'(o_mem), 64'(0));
    chk("t5_rdata0", 64'(o_rdata), 64'(0));
    chk("t5_busy0", 64'(o_busy), 64'(0));
    if_req = 1; if_addr = 8'h45;
    dm_req = 1; dm_we = 0; dm_addr = 8'h46;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    cyc++;
    model_reset();
    check_cycle();
    step();
    chk("t5_iffirst", 64'(o_gnt), 64'(3'b001));
    if_req = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_gnt[1]) dm_req = 0;
    end

    rand_run(800);

    // RD_LAT=3 instance
    do_reset(1'b1);
    dm_req = 1; dm_we = 0; dm_addr = 8'h7F;
    step();
    chk("t6_gnt", 64'(o_gnt), 64'(3'b010));
    dm_req = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_wait", 64'({o_busy, o_ack}), 64'({1'b1, 3'b000}));
    end
    step();
    chk("t6_ack", 64'(o_ack), 64'(3'b010));
    chk("t6_rdata", 64'(o_rdata), 64'(32'hCAFEF00D));
    repeat (2) step();

    rand_run(800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous main memory between three requesters: instruction fetch (if), execute-stage data access (dm) and an external debug/loader port (db).
- Sits between the CPU phase logic and main memory, replacing the dual-port arrangement.
- Serialises accesses through a request/grant/ack handshake with a configurable memory read latency.
- Only one transaction is in flight at any time.

Parameters:
AW, 8, memory word-address width
DW, 32, data width
RD_LAT, 1, cycles from memory-issue cycle to valid mem_rdata (legal 1..4)

Ports:
clk  in  1  clock, rising edge
n_rst  in  1  asynchronous active-low reset
if_req  in  1  fetch read request, held until if_gnt
if_addr  in  AW  fetch address
if_gnt  out  1  one-cycle pulse: fetch request accepted
if_ack  out  1  one-cycle pulse: fetch data valid on rdata
dm_req  in  1  data request, held until dm_gnt
dm_we  in  1  1=write, 0=read
dm_addr  in  AW  data address
dm_wdata  in  DW  write data
dm_gnt  out  1  one-cycle pulse: data request accepted
dm_ack  out  1  one-cycle pulse: read data valid / write done
db_req, db_we, db_addr, db_wdata  in  1/1/AW/DW  debug request, same rules as dm
db_gnt, db_ack  out  1/1  debug grant/ack, same rules as dm
rdata  out  DW  registered read data, shared by all requesters
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid RD_LAT cycles after the mem_en cycle
busy  out  1  high whenever state != IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset puts it in IDLE.
- Reset values: every output 0, rdata=0, last_rr=dm (so fetch wins the first tie).
- IDLE with no request: stay in IDLE.
- IDLE with any req sampled high:
  - Priority: db first. Between if and dm, round-robin: the one not equal to last_rr wins a tie; a lone requester always wins.
  - At the clock edge, latch owner, addr, we and wdata (if has we=0), then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_en=1; mem_we, mem_addr, mem_wdata driven from the latches.
  - <owner>_gnt=1 in this cycle only.
  - last_rr updates to the owner if the owner is if or dm.
  - Next state: write -> RESP; read -> WAIT.
- WAIT: count RD_LAT cycles. On the edge ending the last WAIT cycle, capture rdata<=mem_rdata, then go to RESP.
- RESP (1 cycle):
  - <owner>_ack=1; next state IDLE.
  - rdata holds its value until the next read capture; writes leave rdata unchanged.
- mem_en, mem_we, mem_addr and mem_wdata are 0 outside ISSUE.
- Throughput:
  - Read: 3+RD_LAT cycles from req sampled to return to IDLE.
  - Write: 3 cycles.
  - Arbitration happens only in IDLE; a request made in RESP is seen in the following IDLE cycle.
- Requester side:
  - A req withdrawn before gnt is never served.
  - After gnt, the request inputs are don't-care; the latched copy is used.
  - A requester may re-assert req in the cycle after its ack.
- A db request arriving during another owner's transaction waits; the current transaction is never aborted.
- n_rst asserted in any state: immediate return to IDLE, outputs 0, no ack for the aborted transaction, last_rr reset.
- Address and data widths pass through unchanged; there is no address wrap logic.

Test Plan:
- RD_LAT=1, mem[0x10]=0xDEADBEEF; if_req=1, if_addr=0x10 at cycle 0:
  - if_gnt and mem_en/mem_addr=0x10 at cycle 1.
  - if_ack with rdata=0xDEADBEEF at cycle 3.
  - busy low at cycle 4.
- if_req and dm_req (read 0x20) both held continuously:
  - Grants alternate if, dm, if, dm.
  - No requester is granted twice in a row.
- db write 0x05 <- 0x12345678 simultaneously with if and dm requests:
  - db_gnt first with mem_we=1 and mem_wdata=0x12345678.
  - db_ack one cycle later.
  - if then granted; rdata unchanged by the write.
- db_req asserted during a fetch WAIT: fetch completes with if_ack, then db is granted next.
- RD_LAT=3 read of 0x7F: exactly 3 WAIT cycles; ack at issue+4 with correct rdata.
- n_rst pulsed low during WAIT:
  - Outputs are 0 immediately and no ack appears.
  - After release, a new dm read completes normally with fetch winning the first tie.
